// File: rtl/i2c_mem_arbiter.sv
// Shares a 2**ADDR_W x DATA_W register bank between an I2C slave memory front-end and a CPU bus.
// Optional feature (macro I2C_MEM_WRITE_PROTECT_EN): I2C writes to the top 16 entries are dropped.

module i2c_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_ld,
  input  logic [ADDR_W-1:0] i2c_mm_addr,
  input  logic [DATA_W-1:0] i2c_rx_data,
  input  logic              i2c_rx_done,
  input  logic              i2c_tx_done,
  output logic [DATA_W-1:0] i2c_tx_data,
  output logic [ADDR_W-1:0] i2c_ptr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready
`ifdef I2C_MEM_WRITE_PROTECT_EN
  ,
  output logic              i2c_wp_hit
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    I2C_LD,
    I2C_WR,
    I2C_RD,
    CPU_ACC
  } state_t;

  state_t            state, next_state;
  logic              ld_p, wr_p, rd_p;
  logic              last_i2c;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] wr_byte;
  logic [ADDR_W-1:0] ptr_inc;
  logic              wr_block;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign ptr_inc = i2c_ptr + ADDR_W'(1);

`ifdef I2C_MEM_WRITE_PROTECT_EN
  assign wr_block = &i2c_ptr[ADDR_W-1:ADDR_W-4];
`else
  assign wr_block = 1'b0;
`endif

  // Service selection happens in IDLE; the chosen operation takes effect on the edge
  // entering its service state, so cpu_ready/cpu_rdata are valid during CPU_ACC.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    next_state = IDLE;
    if (state == IDLE) begin
      if (cpu_req && last_i2c) next_state = CPU_ACC;
      else if (ld_p)           next_state = I2C_LD;
      else if (wr_p)           next_state = I2C_WR;
      else if (rd_p)           next_state = I2C_RD;
      else if (cpu_req)        next_state = CPU_ACC;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu_addr;
    mem_wdata = cpu_wdata;
    if (next_state == I2C_WR && !wr_block) begin
      mem_we    = 1'b1;
      mem_waddr = i2c_ptr;
      mem_wdata = wr_byte;
    end else if (next_state == CPU_ACC && cpu_we) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the bank has no reset; keeping it in its own reset-free block lets it map to plain storage.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ld_p        <= 1'b0;
      wr_p        <= 1'b0;
      rd_p        <= 1'b0;
      last_i2c    <= 1'b0;
      ld_addr     <= '0;
      wr_byte     <= '0;
      i2c_ptr     <= '0;
      i2c_tx_data <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
`ifdef I2C_MEM_WRITE_PROTECT_EN
      i2c_wp_hit  <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      cpu_ready <= (next_state == CPU_ACC);
`ifdef I2C_MEM_WRITE_PROTECT_EN
      i2c_wp_hit <= (next_state == I2C_WR) && wr_block;
`endif
      if (next_state != IDLE) last_i2c <= (next_state != CPU_ACC);

      // A pulse arriving in the serve cycle keeps its flag set for another round.
      ld_p <= i2c_ld      | (ld_p && next_state != I2C_LD);
      wr_p <= i2c_rx_done | (wr_p && next_state != I2C_WR);
      rd_p <= i2c_tx_done | (rd_p && next_state != I2C_RD);
      if (i2c_ld)      ld_addr <= i2c_mm_addr;
      if (i2c_rx_done) wr_byte <= i2c_rx_data;

      case (next_state)
        I2C_LD: begin
          i2c_ptr     <= ld_addr;
          i2c_tx_data <= mem[ld_addr];
        end
        I2C_WR: i2c_ptr <= ptr_inc;
        I2C_RD: begin
          i2c_ptr     <= ptr_inc;
          i2c_tx_data <= mem[ptr_inc];
        end
        CPU_ACC: if (!cpu_we) cpu_rdata <= mem[cpu_addr];
        default: ;
      endcase
    end
  end

endmodule
